// File: rtl/tcm_mport_ctrl_pkg.sv
// rtl/tcm_mport_ctrl_pkg.sv - shared defaults and command encoding for the multi-port TCM controller
package tcm_mport_ctrl_pkg;

  localparam int TCM_NCH       = 2;
  localparam int TCM_AW        = 16;
  localparam int TCM_DW        = 32;
  localparam int TCM_RSP_DEPTH = 4;

  typedef enum logic {
    CMD_WRITE = 1'b0,
    CMD_READ  = 1'b1
  } cmd_op_e;

  // index width that stays legal (>=1) for single-entry ranges
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcm_rsp_fifo.sv
// rtl/tcm_rsp_fifo.sv - per-channel response FIFO with occupancy count
module tcm_rsp_fifo
  import tcm_mport_ctrl_pkg::*;
#(
  parameter int  DW    = TCM_DW,
  parameter int  DEPTH = TCM_RSP_DEPTH,
  localparam int PW    = idx_w(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // empty FIFO presents zero so rdata is clean out of reset
  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/tcm_mport_ctrl.sv
// rtl/tcm_mport_ctrl.sv - round-robin multi-master front end for a single-port 1-cycle TCM SRAM
module tcm_mport_ctrl
  import tcm_mport_ctrl_pkg::*;
#(
  parameter int  NCH       = TCM_NCH,
  parameter int  AW        = TCM_AW,
  parameter int  DW        = TCM_DW,
  parameter int  RSP_DEPTH = TCM_RSP_DEPTH,
  localparam int MW        = DW / 8,
  localparam int BW        = $clog2(MW),
  localparam int RAM_AW    = AW - BW,
  localparam int CHW       = idx_w(NCH),
  localparam int CW        = $clog2(RSP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    cmd_valid,
  output logic [NCH-1:0]    cmd_ready,
  input  logic [NCH-1:0]    cmd_read,
  input  logic [NCH*AW-1:0] cmd_addr,
  input  logic [NCH*DW-1:0] cmd_wdata,
  input  logic [NCH*MW-1:0] cmd_wmask,
  output logic [NCH-1:0]    rsp_valid,
  input  logic [NCH-1:0]    rsp_ready,
  output logic [NCH*DW-1:0] rsp_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [MW-1:0]     ram_wem,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout
);

  logic [CHW-1:0]    rr_ptr;
  logic [CHW-1:0]    gnt_idx;
  logic [CHW-1:0]    cand;
  logic              gnt_any;
  logic [NCH-1:0]    eligible;
  logic [NCH-1:0]    infl;
  logic              s1_valid;
  logic              s1_read;
  logic [CHW-1:0]    s1_ch;
  logic [CW-1:0]     occ     [NCH];
  logic [RAM_AW-1:0] addr_a  [NCH];
  logic [DW-1:0]     wdata_a [NCH];
  logic [MW-1:0]     wmask_a [NCH];
  logic [DW-1:0]     push_data;

  // credit counts the stage-1 slot but not same-cycle pops: no rsp_ready -> cmd_ready path
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NCH; i++) begin
      eligible[i] = cmd_valid[i] && ((32'(occ[i]) + 32'(infl[i])) < 32'(RSP_DEPTH));
    end
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_ptr;
    cand    = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = CHW'((32'(rr_ptr) + 32'(k)) % 32'(NCH));
      if (!gnt_any && eligible[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    cmd_ready = '0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wem   = '0;
    ram_din   = '0;
    if (gnt_any) begin
      cmd_ready[gnt_idx] = 1'b1;
      ram_cs   = 1'b1;
      ram_we   = (cmd_op_e'(cmd_read[gnt_idx]) == CMD_WRITE);
      ram_addr = addr_a[gnt_idx];
      ram_wem  = wmask_a[gnt_idx];
      ram_din  = wdata_a[gnt_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= CHW'(NCH - 1);
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_read  <= 1'b0;
    end else begin
      s1_valid <= gnt_any;
      if (gnt_any) begin
        rr_ptr  <= gnt_idx;
        s1_ch   <= gnt_idx;
        s1_read <= cmd_read[gnt_idx];
      end
    end
  end

  assign push_data = s1_read ? ram_dout : '0;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0] fifo_head;

    assign addr_a[i]  = cmd_addr[i*AW + BW +: RAM_AW];
    assign wdata_a[i] = cmd_wdata[i*DW +: DW];
    assign wmask_a[i] = cmd_wmask[i*MW +: MW];
    assign infl[i]    = s1_valid && (s1_ch == CHW'(i));
    assign rsp_valid[i] = (occ[i] != '0);
    assign rsp_rdata[i*DW +: DW] = fifo_head;

    if (BW > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^cmd_addr[i*AW +: BW];
    end

    tcm_rsp_fifo #(
      .DW    (DW),
      .DEPTH (RSP_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (infl[i]),
      .push_data (push_data),
      .pop       (rsp_valid[i] && rsp_ready[i]),
      .head      (fifo_head),
      .count     (occ[i])
    );
  end

endmodule

// File: tb/tb_tcm_mport_ctrl.sv
// tb/tb_tcm_mport_ctrl.sv - self-checking bench for tcm_mport_ctrl
module tb_tcm_mport_ctrl;

  localparam int NCH = 2, AW = 16, DW = 32, MW = 4, DEPTH = 4, RAW = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    cmd_valid, cmd_ready, cmd_read, rsp_valid, rsp_ready;
  logic [NCH*AW-1:0] cmd_addr;
  logic [NCH*DW-1:0] cmd_wdata, rsp_rdata;
  logic [NCH*MW-1:0] cmd_wmask;
  logic              ram_cs, ram_we;
  logic [RAW-1:0]    ram_addr;
  logic [MW-1:0]     ram_wem;
  logic [DW-1:0]     ram_din, ram_dout;

  always #5 clk = ~clk;

  tcm_mport_ctrl #(.NCH(NCH), .AW(AW), .DW(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  function automatic logic [31:0] init_word(input int a);
    return {16'hA5A5, a[15:0]};
  endfunction

  // SRAM macro behaviour: 1-cycle read latency, byte-masked writes
  logic [31:0] sram [int];
  always @(posedge clk) begin
    logic [31:0] w;
    if (ram_cs) begin
      w = sram.exists(int'(ram_addr)) ? sram[int'(ram_addr)] : init_word(int'(ram_addr));
      if (ram_we) begin
        for (int b = 0; b < MW; b++) if (ram_wem[b]) w[b*8 +: 8] = ram_din[b*8 +: 8];
        sram[int'(ram_addr)] = w;
      end else begin
        ram_dout <= w;
      end
    end
  end

  // reference: outstanding responses per channel as timestamped queues, memory as a word map
  typedef struct { int cyc; logic [31:0] data; } exp_t;
  exp_t        expq [NCH][$];
  logic [31:0] mmem [int];
  int last_gnt = NCH - 1;
  int cyc = 0, checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    int g = -1;
    int wa;
    logic [NCH-1:0] exp_rdy;
    logic [AW-1:0] a;
    logic [31:0] w;
    logic vis;
    exp_t e;
    exp_rdy = '0;
    for (int k = 1; k <= NCH; k++) begin
      int c = (last_gnt + k) % NCH;
      if (g < 0 && cmd_valid[c] && expq[c].size() < DEPTH) g = c;
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("cmd_ready", cmd_ready, exp_rdy);
    chk("ram_cs", ram_cs, g >= 0);
    if (g >= 0) begin
      a = cmd_addr[g*AW +: AW];
      chk("ram_we", ram_we, !cmd_read[g]);
      chk("ram_addr", ram_addr, a / MW);
      chk("ram_wem", ram_wem, cmd_wmask[g*MW +: MW]);
      chk("ram_din", ram_din, cmd_wdata[g*DW +: DW]);
    end else begin
      chk("ram_we idle", ram_we, 0);
      chk("ram_addr idle", ram_addr, 0);
      chk("ram_wem idle", ram_wem, 0);
      chk("ram_din idle", ram_din, 0);
    end
    for (int c = 0; c < NCH; c++) begin
      vis = expq[c].size() > 0 && expq[c][0].cyc + 2 <= cyc;
      chk($sformatf("rsp_valid[%0d]", c), rsp_valid[c], vis);
      if (vis) begin
        chk($sformatf("rsp_rdata[%0d]", c), rsp_rdata[c*DW +: DW], expq[c][0].data);
        if (rsp_ready[c]) void'(expq[c].pop_front());
      end
    end
    if (g >= 0) begin
      wa = int'(a / MW);
      w = mmem.exists(wa) ? mmem[wa] : init_word(wa);
      e.cyc = cyc;
      if (cmd_read[g]) begin
        e.data = w;
      end else begin
        e.data = '0;
        for (int b = 0; b < MW; b++)
          if (cmd_wmask[g*MW + b]) w[b*8 +: 8] = cmd_wdata[g*DW + b*8 +: 8];
        mmem[wa] = w;
      end
      expq[g].push_back(e);
      last_gnt = g;
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_idle();
    cmd_valid = '0; cmd_read = '0; cmd_addr = '0; cmd_wdata = '0; cmd_wmask = '0;
  endtask

  task automatic set_ch(input int ch, input logic rd, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    cmd_valid[ch] = 1'b1;
    cmd_read[ch]  = rd;
    cmd_addr[ch*AW +: AW]  = addr;
    cmd_wdata[ch*DW +: DW] = wd;
    cmd_wmask[ch*MW +: MW] = wm;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    for (int c = 0; c < NCH; c++) expq[c].delete();
    last_gnt = NCH - 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] vld, rd; logic [15:0] a0, a1; logic [31:0] wd; logic [3:0] wm;
    logic [1:0] e_rdy; logic e_we; logic [13:0] e_addr; logic [3:0] e_wem; logic [31:0] e_din;
  } vec_t;
  vec_t vecs [9];

  int n0, k, thr;
  logic saw;

  initial begin
    vecs[0] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0, 4'h0, 2'b00, 1'b0, 14'h000, 4'h0, 32'h0};
    vecs[1] = '{2'b01, 2'b01, 16'h0010, 16'h0000, 32'h0, 4'h0, 2'b01, 1'b0, 14'h004, 4'h0, 32'h0};
    vecs[2] = '{2'b10, 2'b00, 16'h0000, 16'h0022, 32'h11223344, 4'b0101,
                2'b10, 1'b1, 14'h008, 4'b0101, 32'h11223344};
    for (int i = 3; i < 9; i++)
      vecs[i] = '{2'b11, 2'b11, 16'h0030, 16'h0040, 32'h0, 4'h0,
                  (i % 2 == 1) ? 2'b01 : 2'b10, 1'b0, (i % 2 == 1) ? 14'h00C : 14'h010, 4'h0, 32'h0};

    rst_n = 1'b0;
    set_idle();
    rsp_ready = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    settle();
    chk("reset cmd_ready", cmd_ready, 0);
    chk("reset ram_cs", ram_cs, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    advance();

    rsp_ready = 2'b11;
    for (int i = 0; i < 9; i++) begin
      cmd_valid = vecs[i].vld; cmd_read = vecs[i].rd;
      cmd_addr  = {vecs[i].a1, vecs[i].a0};
      cmd_wdata = {2{vecs[i].wd}}; cmd_wmask = {2{vecs[i].wm}};
      settle();
      chk($sformatf("vec%0d cmd_ready", i), cmd_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d ram_cs", i), ram_cs, |vecs[i].e_rdy);
      chk($sformatf("vec%0d ram_we", i), ram_we, vecs[i].e_we);
      chk($sformatf("vec%0d ram_addr", i), ram_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d ram_wem", i), ram_wem, vecs[i].e_wem);
      chk($sformatf("vec%0d ram_din", i), ram_din, vecs[i].e_din);
      advance();
    end
    set_idle();
    repeat (4) begin settle(); advance(); end

    // single-read latency, then read back the masked write
    set_ch(0, 1'b1, 16'h0010, '0, '0);
    settle(); chk("lat grant", cmd_ready, 2'b01); advance();
    set_idle();
    settle(); chk("lat T+1 rsp_valid", rsp_valid[0], 0); advance();
    settle(); chk("lat T+2 rsp_valid", rsp_valid[0], 1);
    chk("lat T+2 rdata", rsp_rdata[31:0], 32'hA5A50004); advance();
    set_ch(1, 1'b1, 16'h0020, '0, '0);
    settle(); chk("readback grant", cmd_ready, 2'b10); advance();
    set_idle();
    settle(); advance();
    settle(); chk("readback rsp_valid", rsp_valid[1], 1);
    chk("readback rdata", rsp_rdata[63:32], 32'hA5220044); advance();

    // back-pressure on ch0
    do_reset();
    rsp_ready = 2'b10; n0 = 0; saw = 1'b0;
    for (int j = 0; j < 12; j++) begin
      set_idle();
      set_ch(0, 1'b1, 16'h0100 + 16'(4 * n0), '0, '0);
      set_ch(1, 1'b1, 16'h0200, '0, '0);
      settle();
      if (cmd_ready[0]) n0++;
      if (n0 == 4 && cmd_ready == 2'b10) saw = 1'b1;
      advance();
    end
    chk("bp ch0 accepted", n0, 4);
    chk("bp ch1 granted while ch0 full", saw, 1);
    set_idle(); rsp_ready = 2'b11; k = 0;
    for (int j = 0; j < 8; j++) begin
      settle();
      if (rsp_valid[0]) begin
        chk($sformatf("bp drain %0d", k), rsp_rdata[31:0], {16'hA5A5, 16'h0040 + 16'(k)});
        k++;
      end
      advance();
    end
    chk("bp drained", k, 4);

    // single channel streaming
    do_reset();
    rsp_ready = 2'b11;
    for (int j = 0; j < 12; j++) begin
      set_idle();
      if (j < 8) set_ch(0, 1'b1, 16'h0080 + 16'(4 * j), '0, '0);
      settle();
      if (j < 8) chk($sformatf("stream grant %0d", j), cmd_ready, 2'b01);
      chk($sformatf("stream rsp %0d", j), rsp_valid[0], (j >= 2 && j < 10));
      advance();
    end

    // reset with responses queued
    rsp_ready = 2'b00;
    for (int j = 0; j < 2; j++) begin
      set_idle(); set_ch(0, 1'b1, 16'h0010, '0, '0);
      settle(); advance();
    end
    set_idle();
    repeat (2) begin settle(); advance(); end
    settle(); chk("pre-reset queued", rsp_valid[0], 1); advance();
    rst_n = 1'b0;
    #1;
    chk("async reset rsp_valid", rsp_valid, 0);
    chk("async reset rsp_rdata", rsp_rdata, 0);
    do_reset();
    set_ch(0, 1'b1, 16'h0004, '0, '0);
    set_ch(1, 1'b1, 16'h0008, '0, '0);
    settle(); chk("post-reset first grant", cmd_ready, 2'b01); advance();

    // randomized traffic against the reference
    thr = 2;
    for (int j = 0; j < 1500; j++) begin
      if (j % 150 == 0) thr = (thr == 8) ? 2 : 8;
      cmd_valid = NCH'($urandom);
      cmd_read  = NCH'($urandom);
      for (int c = 0; c < NCH; c++) begin
        cmd_addr[c*AW +: AW]  = 16'($urandom_range(0, 63));
        cmd_wdata[c*DW +: DW] = $urandom;
        cmd_wmask[c*MW +: MW] = 4'($urandom);
        rsp_ready[c] = ($urandom_range(0, 9) < thr);
      end
      settle(); advance();
    end
    set_idle(); rsp_ready = 2'b11;
    repeat (8) begin settle(); advance(); end
    for (int c = 0; c < NCH; c++)
      chk($sformatf("final queue %0d empty", c), expq[c].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcm_mport_ctrl.md
# tcm_mport_ctrl

Parametrised multi-port TCM controller: the next generation of the single-master ITCM/DTCM controllers. It lets `NCH` cmd/rsp masters (e.g. IFU and LSU sharing one unified TCM) reach a single-port, 1-cycle-latency SRAM. It sits between the core's memory ports and the SRAM macro. It adds fair round-robin arbitration, per-channel response buffering with credit-based back-pressure, and in-order write acknowledges.

## Interface
Parameters:
- `NCH`, 2: number of master channels (≥1).
- `AW`, 16: byte-address width of `cmd_addr`.
- `DW`, 32: data width; `MW = DW/8` byte-mask width.
- `RSP_DEPTH`, 4: response FIFO entries per channel (≥2).
- Derived `RAM_AW = AW - $clog2(MW)`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cmd_valid`  in  NCH  per-channel request.
- `cmd_ready`  out  NCH  per-channel accept (combinational grant).
- `cmd_read`  in  NCH  1 = read, 0 = write.
- `cmd_addr`  in  NCH*AW  byte address, channel i in bits [i*AW +: AW].
- `cmd_wdata`  in  NCH*DW  write data.
- `cmd_wmask`  in  NCH*MW  byte write enables.
- `rsp_valid`  out  NCH  response available.
- `rsp_ready`  in  NCH  master consumes response.
- `rsp_rdata`  out  NCH*DW  read data; 0 for write acks.
- `ram_cs`  out  1  SRAM access this cycle.
- `ram_we`  out  1  SRAM write.
- `ram_addr`  out  RAM_AW  SRAM word address.
- `ram_wem`  out  MW  SRAM byte write mask.
- `ram_din`  out  DW  SRAM write data.
- `ram_dout`  in  DW  SRAM read data, valid the cycle after `ram_cs`.

## Operation
- Channel i is eligible when `cmd_valid[i]` and `occ[i] + infl[i] < RSP_DEPTH`. `occ` is the FIFO count. `infl` is 1 if the stage-1 register holds a command for i.
- Round-robin arbiter: search starts at `rr_ptr+1` mod NCH. The first eligible channel gets `cmd_ready[i]=1`; all others get 0. `rr_ptr` updates to the granted index only on a grant.
- On grant: `ram_cs=1`, `ram_we=!cmd_read[i]`, `ram_addr=cmd_addr[i][AW-1:$clog2(MW)]` (low byte bits ignored), `ram_wem=cmd_wmask[i]`, `ram_din=cmd_wdata[i]`.
- With no grant: `ram_cs=0`, `ram_we=0`, `ram_wem=0`. `ram_addr`/`ram_din` are don't-care but must be driven to 0.
- Stage 1 (registered): {valid, channel, read}. The next cycle, the response pushes into that channel's FIFO: `ram_dout` if read, 0 if write.
- Per-channel FIFO: `rsp_valid = occ!=0`, `rsp_rdata` = head. Pop on `rsp_valid & rsp_ready`. Push and pop may occur in the same cycle (occ unchanged). The credit rule makes overflow impossible.
- `rsp_valid`/`rsp_rdata` hold stable while `rsp_valid & !rsp_ready`.
- Responses per channel are returned in command order. There is no ordering between channels.

## Timing
- Reset values: `rr_ptr=NCH-1` (channel 0 wins first), stage-1 valid 0, all `occ=0`, `rsp_valid=0`, `rsp_rdata=0`. `ram_cs`/`cmd_ready` are 0 when no `cmd_valid`.
- Latency: handshake in cycle T, SRAM sampled at end of T, `ram_dout` valid in T+1, `rsp_valid` high in T+2.
- Throughput: 1 SRAM access/cycle total. A single channel streams at full rate when `RSP_DEPTH≥3` and `rsp_ready=1`. Credit excludes same-cycle pops, so there is no `rsp_ready`→`cmd_ready` path.
- Back-pressure: a channel with `occ+infl=RSP_DEPTH` is skipped; others still get granted.
- Reset mid-operation: stage-1 and all FIFO contents are discarded asynchronously. A pending SRAM write that has already been sampled completes.

## Structure
- Shared defines: default `TCM_NCH`, `TCM_AW`, `TCM_DW`, `TCM_RSP_DEPTH`, and the read/write encoding of `cmd_read`.
- Sub-module `tcm_rsp_fifo`: parametrised `DW`×`RSP_DEPTH` synchronous FIFO with count output. It is instantiated NCH times in a generate loop.
- The arbiter stays inline (rotate-priority-encode, ~40 lines).

## Test plan
- Single read: ch0 read addr 0x0010, `ram_dout=0xA5A5_0001` → `ram_addr=0x004` in T, `rsp_valid[0]` in T+2 with `rsp_rdata=0xA5A5_0001`.
- Masked write: ch1 write 0x0020, wdata 0x1122_3344, wmask 4'b0101 → `ram_we=1`, `ram_wem=0101`; write ack at T+2 with rdata 0.
- Contention: ch0 and ch1 both valid for 6 cycles → grants alternate 0,1,0,1,0,1.
- Back-pressure: ch0 `rsp_ready=0`, 6 reads requested → exactly `RSP_DEPTH`(4) accepted, then `cmd_ready[0]=0` while ch1 still granted. Releasing `rsp_ready` drains responses in order.
- Streaming: ch0 alone, `rsp_ready=1`, 8 back-to-back reads → 8 consecutive grants, 8 consecutive responses.
- Reset mid-flight: assert `rst_n=0` with 2 responses queued → `rsp_valid=0` immediately. After release, ch0 wins first.
